// File: rtl/throw_pkg.sv
// Shared types for the throw hit detector: result codes, FSM states and coordinate width.
package throw_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [2:0] {
        RES_NONE    = 3'd0,
        RES_HIT     = 3'd1,
        RES_LAND    = 3'd2,
        RES_OOB     = 3'd3,
        RES_TIMEOUT = 3'd4
    } result_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        TRACK,
        RESULT
    } hit_state_t;

endpackage

// File: rtl/throw_box_cmp.sv
// Combinational point-in-box test; upper bounds carry one extra bit so a target
// near the top of the coordinate range cannot wrap its box edge back to zero.
module throw_box_cmp
    import throw_pkg::*;
#(
    parameter int TGT_W = 16,
    parameter int TGT_H = 32
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] tx,
    input  logic [COORD_W-1:0] ty,
    output logic               in_box
);

    localparam logic [COORD_W:0] W_EXT = TGT_W[COORD_W:0];
    localparam logic [COORD_W:0] H_EXT = TGT_H[COORD_W:0];

    logic [COORD_W:0] x_hi;
    logic [COORD_W:0] y_hi;

    assign x_hi = {1'b0, tx} + W_EXT;
    assign y_hi = {1'b0, ty} + H_EXT;

    assign in_box = (x >= tx) && ({1'b0, x} < x_hi) &&
                    (y >= ty) && ({1'b0, y} < y_hi);

endmodule

// File: rtl/throw_hit_detect.sv
// Follows one throw on the trajectory stream and classifies it as hit, landing,
// out of bounds or timeout; the result is held until the consumer acks it.
module throw_hit_detect
    import throw_pkg::*;
#(
    parameter int TGT_W   = 16,
    parameter int TGT_H   = 32,
    parameter int X_LIMIT = 4000,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               throw_start,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic [COORD_W-1:0] target_x,
    input  logic [COORD_W-1:0] target_y,
    output logic               result_valid,
    output logic [2:0]         result_code,
    input  logic               result_ack,
    output logic [COORD_W-1:0] land_x,
    output logic [7:0]         hit_count,
    output logic               busy
);

    localparam int               TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [COORD_W:0] X_LIM   = X_LIMIT[COORD_W:0];

    hit_state_t         state;
    logic [COORD_W-1:0] tgt_x;
    logic [COORD_W-1:0] tgt_y;
    logic [COORD_W-1:0] samp_x;
    logic [COORD_W-1:0] samp_y;
    logic               airborne;
    logic [TO_W-1:0]    to_cnt;

    logic    new_sample;
    logic    in_box;
    logic    at_limit;
    logic    tracking;
    logic    decided;
    result_t dec_code;

    // The incoming pair is judged against the last registered pair, so a deciding
    // sample shows up as result_valid one edge after it is presented.
    assign new_sample = {x_pos, y_pos} != {samp_x, samp_y};
    assign at_limit   = {1'b0, x_pos} >= X_LIM;
    assign tracking   = (state == ARMED) || (state == TRACK);

    throw_box_cmp #(
        .TGT_W (TGT_W),
        .TGT_H (TGT_H)
    ) u_box (
        .x      (x_pos),
        .y      (y_pos),
        .tx     (tgt_x),
        .ty     (tgt_y),
        .in_box (in_box)
    );

    always_comb begin
        decided  = 1'b0;
        dec_code = RES_NONE;
        if (tracking) begin
            if (new_sample) begin
                // y == 0 before the projectile has left the ground is the launch point.
                if (in_box) begin
                    decided  = 1'b1;
                    dec_code = RES_HIT;
                end else if (airborne && (y_pos == '0)) begin
                    decided  = 1'b1;
                    dec_code = RES_LAND;
                end else if (at_limit) begin
                    decided  = 1'b1;
                    dec_code = RES_OOB;
                end
            end else if (to_cnt == TO_LAST) begin
                decided  = 1'b1;
                dec_code = RES_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tgt_x        <= '0;
            tgt_y        <= '0;
            samp_x       <= '0;
            samp_y       <= '0;
            airborne     <= 1'b0;
            to_cnt       <= '0;
            result_valid <= 1'b0;
            result_code  <= RES_NONE;
            land_x       <= '0;
            hit_count    <= '0;
            busy         <= 1'b0;
        end else begin
            samp_x <= x_pos;
            samp_y <= y_pos;
            case (state)
                IDLE: begin
                    if (throw_start) begin
                        state    <= ARMED;
                        tgt_x    <= target_x;
                        tgt_y    <= target_y;
                        airborne <= 1'b0;
                        to_cnt   <= '0;
                        busy     <= 1'b1;
                    end
                end
                ARMED, TRACK: begin
                    if (decided) begin
                        state        <= RESULT;
                        result_valid <= 1'b1;
                        result_code  <= dec_code;
                        land_x       <= x_pos;
                        busy         <= 1'b0;
                        if ((dec_code == RES_HIT) && (hit_count != 8'hFF))
                            hit_count <= hit_count + 8'd1;
                    end else if (new_sample) begin
                        state  <= TRACK;
                        to_cnt <= '0;
                        if (y_pos != '0)
                            airborne <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESULT: begin
                    if (result_ack) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        result_code  <= RES_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_throw_hit_detect.sv
// Directed bench for throw_hit_detect: hand-computed outcomes for hit, land,
// launch point, timeout, out of bounds, hit priority, saturation and reset.
module tb_throw_hit_detect;

    logic        clk;
    logic        rst;
    logic        throw_start;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic [11:0] target_x;
    logic [11:0] target_y;
    logic        result_valid;
    logic [2:0]  result_code;
    logic        result_ack;
    logic [11:0] land_x;
    logic [7:0]  hit_count;
    logic        busy;

    int n_checks;
    int n_fail;

    localparam logic [2:0] C_NONE = 3'd0;
    localparam logic [2:0] C_HIT  = 3'd1;
    localparam logic [2:0] C_LAND = 3'd2;
    localparam logic [2:0] C_OOB  = 3'd3;
    localparam logic [2:0] C_TOUT = 3'd4;

    // Box is made taller so the (200,190) sample of the first throw lands inside it.
    throw_hit_detect #(
        .TGT_W   (16),
        .TGT_H   (256),
        .X_LIMIT (4000),
        .TIMEOUT (1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .throw_start  (throw_start),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .target_x     (target_x),
        .target_y     (target_y),
        .result_valid (result_valid),
        .result_code  (result_code),
        .result_ack   (result_ack),
        .land_x       (land_x),
        .hit_count    (hit_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_throw(input int tx, input int ty, input int x, input int y);
        target_x    = 12'(tx);
        target_y    = 12'(ty);
        x_pos       = 12'(x);
        y_pos       = 12'(y);
        throw_start = 1'b1;
        tick();
        throw_start = 1'b0;
    endtask

    task automatic sample(input int x, input int y);
        x_pos = 12'(x);
        y_pos = 12'(y);
        tick();
    endtask

    task automatic ack();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    initial begin
        int cnt;
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        throw_start = 1'b0;
        result_ack  = 1'b0;
        x_pos       = '0;
        y_pos       = '0;
        target_x    = '0;
        target_y    = '0;
        tick(2);
        rst = 1'b0;
        tick();
        check("rst_valid", result_valid, 0);
        check("rst_code", result_code, C_NONE);
        check("rst_land_x", land_x, 0);
        check("rst_hits", hit_count, 0);
        check("rst_busy", busy, 0);

        // T1: hit at (200,190)
        start_throw(200, 0, 0, 0);
        check("t1_busy", busy, 1);
        sample(100, 100);
        check("t1_no_result", result_valid, 0);
        sample(200, 190);
        check("t1_valid", result_valid, 1);
        check("t1_code", result_code, C_HIT);
        check("t1_land_x", land_x, 200);
        check("t1_hits", hit_count, 1);
        check("t1_busy_res", busy, 0);
        // ack together with a new start: ack wins, start is dropped
        result_ack  = 1'b1;
        throw_start = 1'b1;
        tick();
        result_ack  = 1'b0;
        throw_start = 1'b0;
        check("t1_ack_valid", result_valid, 0);
        check("t1_start_dropped", busy, 0);
        tick();
        check("t1_still_idle", busy, 0);

        // T2: full arc landing at x=1900
        start_throw(3000, 0, 0, 0);
        sample(500, 300);
        result_ack = 1'b1;
        sample(1000, 400);
        result_ack = 1'b0;
        check("t2_stray_ack", busy, 1);
        sample(1500, 300);
        check("t2_no_result", result_valid, 0);
        sample(1900, 0);
        check("t2_valid", result_valid, 1);
        check("t2_code", result_code, C_LAND);
        check("t2_land_x", land_x, 1900);
        check("t2_hits", hit_count, 1);
        ack();

        // T3: launch point (0,0) is never a landing
        start_throw(3000, 0, 7, 7);
        sample(0, 0);
        check("t3_busy", busy, 1);
        check("t3_no_land", result_valid, 0);
        sample(100, 100);
        sample(200, 0);
        check("t3_code", result_code, C_LAND);
        check("t3_land_x", land_x, 200);
        ack();

        // T4: frozen stream times out 1024 cycles after start
        start_throw(3000, 0, 10, 20);
        cnt = 0;
        while (!result_valid && cnt < 2000) begin
            tick();
            cnt++;
        end
        check("t4_timeout_cycles", cnt, 1024);
        check("t4_code", result_code, C_TOUT);
        check("t4_land_x", land_x, 10);
        tick(20);
        check("t4_held_valid", result_valid, 1);
        check("t4_held_code", result_code, C_TOUT);
        ack();
        check("t4_ack_valid", result_valid, 0);
        check("t4_ack_busy", busy, 0);

        // T5: out of bounds, then in-box ground sample takes HIT priority
        start_throw(100, 0, 3800, 0);
        sample(3900, 50);
        check("t5_no_result", result_valid, 0);
        sample(4000, 50);
        check("t5_oob_code", result_code, C_OOB);
        check("t5_oob_land_x", land_x, 4000);
        ack();
        start_throw(500, 0, 300, 0);
        sample(400, 60);
        sample(505, 0);
        check("t5_prio_code", result_code, C_HIT);
        check("t5_prio_land_x", land_x, 505);
        check("t5_hits", hit_count, 2);
        ack();

        // T6: drive hit_count to saturation, then reset mid-track
        for (int i = 0; i < 253; i++) begin
            start_throw(200, 0, 0, 0);
            sample(205, 5);
            ack();
        end
        check("t6_hits_255", hit_count, 255);
        start_throw(200, 0, 0, 0);
        sample(205, 5);
        check("t6_sat_code", result_code, C_HIT);
        check("t6_sat_hits", hit_count, 255);
        ack();
        start_throw(3000, 0, 0, 0);
        sample(100, 100);
        check("t6_track_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid", result_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_code", result_code, C_NONE);
        check("t6_rst_hits", hit_count, 0);
        sample(205, 5);
        check("t6_idle_no_result", result_valid, 0);
        check("t6_idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
